prbs9_checker: RTL and testbench

Receive-side companion to the PRBS9 generator (x^9 + x^5 + 1, stream bit b[n+9] = b[n] ^ b[n+4]).
- Self-synchronises to an incoming serial PRBS9 stream.
- Declares lock, then predicts each bit from a free-running local register and counts bit errors.
- Sits at the end of the link under test, closing the BER measurement loop.

---
 rtl/prbs9_checker.sv | 174 +++++++++++++++++
 tb/tb_prbs9_checker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs9_checker.sv
// prbs9_checker
//   Receive-side PRBS9 (x^9 + x^5 + 1) checker. It self-synchronises to a
//   serial stream, declares lock after LOCK_MATCHES consecutive correct
//   predictions, then free-runs its local register and counts bit errors.
//   It drops lock when UNLOCK_ERRS errors land inside one UNLOCK_WINDOW-bit
//   window.
//
//   Optional build macro: PRBS9_CHK_SATURATE_EN. When it is defined, the
//   error and bit counters saturate at all-ones instead of wrapping.
//
// Ports
//   clk          system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_ctrl       bit-valid strobe
//   i_bit        received PRBS9 bit
//   i_clr_cnt    synchronous clear of both counters; lock is unaffected
//   o_locked     1 while in LOCKED
//   o_err_pulse  one-cycle pulse per error detected while LOCKED
//   o_err_count  errors counted while LOCKED
//   o_bit_count  valid bits compared while LOCKED
module prbs9_checker #(
  parameter int LOCK_MATCHES  = 16,
  parameter int UNLOCK_WINDOW = 64,
  parameter int UNLOCK_ERRS   = 8,
  parameter int ERR_CNT_W     = 32,
  parameter int BIT_CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_ctrl,
  input  logic                 i_bit,
  input  logic                 i_clr_cnt,
  output logic                 o_locked,
  output logic                 o_err_pulse,
  output logic [ERR_CNT_W-1:0] o_err_count,
  output logic [BIT_CNT_W-1:0] o_bit_count
);

  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int WW = $clog2(UNLOCK_WINDOW + 1);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);

  localparam logic [MW-1:0]        M_ONE    = MW'(1);
  localparam logic [MW-1:0]        M_LAST   = MW'(LOCK_MATCHES - 1);
  localparam logic [WW-1:0]        W_ONE    = WW'(1);
  localparam logic [WW-1:0]        W_LAST   = WW'(UNLOCK_WINDOW - 1);
  localparam logic [EW-1:0]        E_ONE    = EW'(1);
  localparam logic [EW-1:0]        E_LAST   = EW'(UNLOCK_ERRS - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [8:0]             r_q, r_d;        // r[0] newest, r[8] oldest
  logic [3:0]             fill_q, fill_d;
  logic [MW-1:0]          match_q, match_d;
  logic [WW-1:0]          win_q, win_d;
  logic [EW-1:0]          werr_q, werr_d;
  logic [ERR_CNT_W-1:0]   errc_q, errc_d, errc_inc;
  logic [BIT_CNT_W-1:0]   bitc_q, bitc_d, bitc_inc;
  logic                   pulse_d, pulse_q;
  logic                   locked_q;
  logic                   exp_bit, mism;

  assign exp_bit = r_q[8] ^ r_q[4];
  assign mism    = i_bit ^ exp_bit;

  // Counter increment, wrapping or saturating depending on build.
  always_comb begin
    errc_inc = errc_q + ERR_ONE;
    bitc_inc = bitc_q + BIT_ONE;
`ifdef PRBS9_CHK_SATURATE_EN
    if (&errc_q) errc_inc = errc_q;
    if (&bitc_q) bitc_inc = bitc_q;
`else
`endif
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    errc_d  = errc_q;
    bitc_d  = bitc_q;
    pulse_d = 1'b0;
    if (i_ctrl) begin
      unique case (state_q)
        SEARCH: begin
          r_d    = {r_q[7:0], i_bit};
          fill_d = fill_q + 4'd1;
          if (fill_q == 4'd8) begin
            state_d = VERIFY;
            match_d = '0;
          end
        end
        VERIFY: begin
          r_d = {r_q[7:0], i_bit};
          // An all-zero history predicts zeros forever; never lock on it.
          if (!mism && (r_q != 9'd0)) begin
            match_d = match_q + M_ONE;
            if (match_q == M_LAST) begin
              state_d = LOCKED;
              win_d   = '0;
              werr_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Feed back the prediction so received errors do not propagate.
          r_d    = {r_q[7:0], exp_bit};
          bitc_d = bitc_inc;
          if (mism) begin
            pulse_d = 1'b1;
            errc_d  = errc_inc;
            werr_d  = werr_q + E_ONE;
          end
          // Loss of lock beats the window wrap on the same bit.
          if (mism && (werr_q == E_LAST)) begin
            state_d = SEARCH;
            fill_d  = '0;
          end else if (win_q == W_LAST) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d = win_q + W_ONE;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (i_clr_cnt) begin
      errc_d = '0;
      bitc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q  <= SEARCH;
      r_q      <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      errc_q   <= '0;
      bitc_q   <= '0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      errc_q   <= errc_d;
      bitc_q   <= bitc_d;
      pulse_q  <= pulse_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  assign o_locked    = locked_q;
  assign o_err_pulse = pulse_q;
  assign o_err_count = errc_q;
  assign o_bit_count = bitc_q;

endmodule

// File: tb/tb_prbs9_checker.sv
// tb_prbs9_checker
//   Scoreboard bench for prbs9_checker. A behavioural model computes the
//   expected outputs as each cycle's stimulus is driven; those are queued
//   and compared one cycle later. A second instance with 4-bit counters
//   exercises counter wrap (or saturation when PRBS9_CHK_SATURATE_EN is set).
module tb_prbs9_checker;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1, i_ctrl = 1'b0, i_bit = 1'b0, i_clr_cnt = 1'b0;
  logic        locked, pulse, locked4, pulse4;
  logic [31:0] errc, bitc;
  logic [3:0]  errc4, bitc4;

  always #5 clk = ~clk;

  prbs9_checker dut (
    .clk(clk), .i_reset(i_reset), .i_ctrl(i_ctrl), .i_bit(i_bit),
    .i_clr_cnt(i_clr_cnt), .o_locked(locked), .o_err_pulse(pulse),
    .o_err_count(errc), .o_bit_count(bitc)
  );

  prbs9_checker #(.ERR_CNT_W(4), .BIT_CNT_W(4)) dut4 (
    .clk(clk), .i_reset(i_reset), .i_ctrl(i_ctrl), .i_bit(i_bit),
    .i_clr_cnt(i_clr_cnt), .o_locked(locked4), .o_err_pulse(pulse4),
    .o_err_count(errc4), .o_bit_count(bitc4)
  );

  typedef struct {
    bit     locked;
    bit     pulse;
    longint errc, bitc, errc4, bitc4;
  } exp_t;

  exp_t   exp_q[$];
  int     n_chk = 0, n_err = 0;
  int     pulse_cnt = 0, lock_seen = 0;

  // ---- reference model -------------------------------------------------
  bit     hist[$];     // hist[0] oldest of the last nine received/predicted bits
  int     m_state = 0; // 0 search, 1 verify, 2 locked
  int     m_fill = 0, m_match = 0, m_win = 0, m_werr = 0;
  longint m_errc = 0, m_bitc = 0, m_errc4 = 0, m_bitc4 = 0;
  bit     m_pulse = 0;
  logic [8:0] g = 9'h1FF;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic longint inc(longint v, int w);
    longint mx = (longint'(1) << w) - 1;
`ifdef PRBS9_CHK_SATURATE_EN
    if (v == mx) return v;
`endif
    return (v + 1) & mx;
  endfunction

  task automatic hshift(bit x);
    hist.push_back(x);
    void'(hist.pop_front());
  endtask

  task automatic model_step(bit rst, bit ctrl, bit b, bit clr);
    bit e, rnz;
    m_pulse = 0;
    if (rst) begin
      hist.delete();
      repeat (9) hist.push_back(1'b0);
      m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
      m_errc = 0; m_bitc = 0; m_errc4 = 0; m_bitc4 = 0;
      return;
    end
    if (ctrl) begin
      e   = hist[0] ^ hist[4];
      rnz = 0;
      foreach (hist[k]) rnz |= hist[k];
      case (m_state)
        0: begin
          hshift(b);
          m_fill++;
          if (m_fill == 9) begin m_state = 1; m_match = 0; end
        end
        1: begin
          hshift(b);
          if (b == e && rnz) begin
            m_match++;
            if (m_match == 16) begin m_state = 2; m_win = 0; m_werr = 0; end
          end else m_match = 0;
        end
        default: begin
          hshift(e);
          m_bitc  = inc(m_bitc, 32);
          m_bitc4 = inc(m_bitc4, 4);
          if (b != e) begin
            m_pulse = 1;
            m_errc  = inc(m_errc, 32);
            m_errc4 = inc(m_errc4, 4);
            m_werr++;
          end
          if (m_werr == 8) begin
            m_state = 0; m_fill = 0;
          end else begin
            m_win++;
            if (m_win == 64) begin m_win = 0; m_werr = 0; end
          end
        end
      endcase
    end
    if (clr) begin m_errc = 0; m_bitc = 0; m_errc4 = 0; m_bitc4 = 0; end
  endtask

  // ---- stimulus helpers ------------------------------------------------
  task automatic step(bit rst, bit ctrl, bit b, bit clr);
    exp_t e;
    i_reset = rst; i_ctrl = ctrl; i_bit = b; i_clr_cnt = clr;
    model_step(rst, ctrl, b, clr);
    e.locked = (m_state == 2); e.pulse = m_pulse;
    e.errc = m_errc; e.bitc = m_bitc; e.errc4 = m_errc4; e.bitc4 = m_bitc4;
    exp_q.push_back(e);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("sb_locked", locked, e.locked);
    chk("sb_locked4", locked4, e.locked);
    chk("sb_pulse", pulse, e.pulse);
    chk("sb_errc", errc, e.errc);
    chk("sb_bitc", bitc, e.bitc);
    chk("sb_errc4", errc4, e.errc4);
    chk("sb_bitc4", bitc4, e.bitc4);
    if (pulse) pulse_cnt++;
    if (locked) lock_seen++;
  endtask

  task automatic next_gen(output bit b);
    b = g[8];
    g = {g[7:0], g[8] ^ g[4]};
  endtask

  task automatic clean(int n);
    bit b;
    repeat (n) begin next_gen(b); step(0, 1, b, 0); end
  endtask

  task automatic flip(int n);
    bit b;
    repeat (n) begin next_gen(b); step(0, 1, ~b, 0); end
  endtask

  task automatic align_window;
    while (m_win != 0) clean(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit b;
    repeat (9) hist.push_back(1'b0);

    // Reset state
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    chk("rst_locked", locked, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_errc", errc, 0);
    chk("rst_bitc", bitc, 0);

    // Clean stream: lock after exactly 25 valid bits, then 1000 clean bits
    g = 9'h1FF;
    clean(24);
    chk("lock_at_24", locked, 0);
    clean(1);
    chk("lock_at_25", locked, 1);
    pulse_cnt = 0;
    clean(1000);
    chk("clean_bitc", bitc, 1000);
    chk("clean_errc", errc, 0);
    chk("clean_pulses", pulse_cnt, 0);

    // Clear with a simultaneous valid bit: clear wins, lock kept
    next_gen(b);
    step(0, 1, b, 1);
    chk("clr_bitc", bitc, 0);
    chk("clr_errc", errc, 0);
    chk("clr_locked", locked, 1);

    // Single inverted bit at position 500
    clean(499);
    flip(1);
    chk("single_pulse", pulse, 1);
    chk("single_errc", errc, 1);
    chk("single_locked", locked, 1);
    clean(1);
    chk("no_propagate_pulse", pulse, 0);
    chk("no_propagate_errc", errc, 1);
    chk("single_bitc", bitc, 501);
    clean(100);
    chk("single_errc_hold", errc, 1);

    // 7 errors per window across a wrap: window error count clears, lock kept
    align_window();
    flip(7);
    clean(57);
    flip(7);
    chk("win_wrap_locked", locked, 1);
    chk("win_wrap_errc", errc, 15);

    // 8 errors in one window: unlock on the 8th, then re-lock after 25 bits
    clean(1);
    align_window();
    flip(7);
    chk("burst7_locked", locked, 1);
    flip(1);
    chk("burst8_unlocked", locked, 0);
    chk("burst8_errc", errc, 23);
    clean(24);
    chk("relock_24", locked, 0);
    clean(1);
    chk("relock_25", locked, 1);
    chk("relock_errc_hold", errc, 23);

    // Reset mid-lock overrides a pending error pulse
    flip(1);
    chk("pre_rst_pulse", pulse, 1);
    next_gen(b);
    step(1, 1, ~b, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_pulse", pulse, 0);
    chk("midrst_errc", errc, 0);
    chk("midrst_bitc", bitc, 0);

    // Constant 0 and constant 1 streams never lock
    lock_seen = 0;
    repeat (200) step(0, 1, 0, 0);
    chk("zeros_locked", lock_seen, 0);
    chk("zeros_bitc", bitc, 0);
    chk("zeros_errc", errc, 0);
    repeat (200) step(0, 1, 1, 0);
    chk("ones_locked", lock_seen, 0);

    // Strobe toggling every cycle; idle cycles carry junk bits
    step(1, 0, 0, 0);
    g = 9'h1FF;
    for (int i = 0; i < 25; i++) begin
      if (i == 24) chk("toggle_lock_24", locked, 0);
      clean(1);
      step(0, 0, 1'($urandom), 0);
    end
    chk("toggle_lock_25", locked, 1);
    for (int i = 0; i < 20; i++) begin
      clean(1);
      step(0, 0, 1'($urandom), 0);
    end
    chk("toggle_bitc", bitc, 20);
    step(0, 0, 1'($urandom), 1);
    chk("toggle_clr_bitc", bitc, 0);
    chk("toggle_clr_locked", locked, 1);

    // 20 errors spread across windows, 4-bit counters wrap or saturate
    for (int i = 0; i < 20; i++) begin
      flip(1);
      clean(9);
    end
    chk("spread_locked", locked, 1);
    chk("spread_errc", errc, 20);
    chk("spread_bitc", bitc, 200);
`ifdef PRBS9_CHK_SATURATE_EN
    chk("spread_errc4", errc4, 15);
    chk("spread_bitc4", bitc4, 15);
`else
    chk("spread_errc4", errc4, 4);
    chk("spread_bitc4", bitc4, 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
